// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Prefetching fetch stage with credit-limited FIFO and redirect.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_instr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] r_fetch_pc;
    logic [DATA_WIDTH-1:0] r_rsp_pc;
    logic [CNT_W-1:0]      r_outstanding;
    logic [CNT_W-1:0]      r_drop_cnt;
    logic [CNT_W-1:0]      r_count;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem_pc    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_instr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_hold_pc;
    logic [DATA_WIDTH-1:0] r_hold_instr;

    logic                  w_credit;
    logic                  w_req_fire;
    logic                  w_rsp_ok;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_redirect_aligned;

    // Buffered plus in-flight words may never exceed the FIFO capacity.
    assign w_credit = ({1'b0, r_count} + {1'b0, r_outstanding}) < (CNT_W + 1)'(FIFO_DEPTH);

    assign imem_req_valid     = !rst && !redirect_valid && w_credit;
    assign imem_req_addr      = r_fetch_pc;
    assign w_req_fire         = imem_req_valid && imem_req_ready;
    assign w_rsp_ok           = imem_rsp_valid && (r_outstanding != '0);
    assign w_push             = w_rsp_ok && (r_drop_cnt == '0) && !redirect_valid;
    assign w_redirect_aligned = redirect_pc & ~(DATA_WIDTH'(3));

    assign out_valid = (r_count != '0) && !redirect_valid;
    assign w_pop     = out_valid && out_ready;
    // Outputs fall back to the last presented values whenever nothing is valid.
    assign out_pc    = out_valid ? r_mem_pc[r_rd_ptr]    : r_hold_pc;
    assign out_instr = out_valid ? r_mem_instr[r_rd_ptr] : r_hold_instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_hold_pc     <= '0;
            r_hold_instr  <= '0;
        end else begin
            r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp_ok);
            r_hold_pc     <= out_pc;
            r_hold_instr  <= out_instr;
            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_aligned;
                r_rsp_pc   <= w_redirect_aligned;
                r_drop_cnt <= r_outstanding - CNT_W'(w_rsp_ok);
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
                end
                if (w_rsp_ok && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    r_rsp_pc <= r_rsp_pc + DATA_WIDTH'(4);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_rsp_pc;
            r_mem_instr[r_wr_ptr] <= imem_rsp_data;
        end
    end

    // A response with nothing outstanding is a memory protocol violation.
    a_rsp_has_request : assert property (
        @(posedge clk) disable iff (rst) imem_rsp_valid |-> (r_outstanding != '0)
    );

endmodule
`default_nettype wire
